// File: rtl/dat_read_phys_pkg.sv
// Shared definitions for the SD DAT read path: default widths, one-hot read states, CRC16 step.
package dat_read_phys_pkg;

  localparam int DAT_FIFO_WIDTH      = 32;
  localparam int DAT_BLOCK_SZ_WIDTH  = 12;
  localparam int DAT_BLOCK_CNT_WIDTH = 16;
  localparam int DAT_TIMEOUT_WIDTH   = 16;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [4:0] {
    ST_IDLE       = 5'b00001,
    ST_WAIT_START = 5'b00010,
    ST_RECV_DATA  = 5'b00100,
    ST_RECV_CRC   = 5'b01000,
    ST_RECV_END   = 5'b10000
  } rd_state_t;

  // One serial step of x^16+x^12+x^5+1, data bit entering at the MSB side.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/dat_read_phys_if.sv
// Rx FIFO write port of the DAT read path; master side is the PHY, slave side the FIFO.
interface dat_read_phys_if
  import dat_read_phys_pkg::*;
#(
  parameter int FIFO_WIDTH = DAT_FIFO_WIDTH
);

  logic                  rx_buf_full;
  logic                  rx_buf_wr_enb;
  logic [FIFO_WIDTH-1:0] rx_buf_din_out;

  modport master (
    input  rx_buf_full,
    output rx_buf_wr_enb,
    output rx_buf_din_out
  );

  modport slave (
    output rx_buf_full,
    input  rx_buf_wr_enb,
    input  rx_buf_din_out
  );

endinterface

// File: rtl/sd_crc16.sv
// Bit-serial CRC16 (x^16+x^12+x^5+1, init 0) for one SD DAT line; shared with the write path.
module sd_crc16
  import dat_read_phys_pkg::*;
(
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge sd_clk) begin
    if (rst || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc16_next(crc, din);
    end
  end

endmodule

// File: rtl/dat_read_phys.sv
// SD DAT[3:0] read-path PHY: start bit, payload deserialization into Rx FIFO words, CRC16, end bit.
// Define DAT_RD_CRC_CHECK_EN to build the four per-line CRC16 checkers; otherwise crc_err is tied 0.
module dat_read_phys
  import dat_read_phys_pkg::*;
#(
  parameter int FIFO_WIDTH      = DAT_FIFO_WIDTH,
  parameter int BLOCK_SZ_WIDTH  = DAT_BLOCK_SZ_WIDTH,
  parameter int BLOCK_CNT_WIDTH = DAT_BLOCK_CNT_WIDTH,
  parameter int TIMEOUT_WIDTH   = DAT_TIMEOUT_WIDTH
) (
  input  logic                       sd_clk,
  input  logic                       rst,
  input  logic [3:0]                 DAT_din,
  input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
  input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
  input  logic                       multiple,
  input  logic                       read_flag,
  input  logic [TIMEOUT_WIDTH-1:0]   read_timeout,
  dat_read_phys_if.master            rx_if,
  output logic                       rd_busy,
  output logic                       tf_finished,
  output logic                       crc_err,
  output logic                       end_bit_err,
  output logic                       timeout_err,
  output logic                       overrun_err
);

  localparam int NIBS      = FIFO_WIDTH / 4;
  localparam int NIB_IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int NL_W      = BLOCK_SZ_WIDTH + 1;

  rd_state_t                  state, state_nxt;
  logic [NL_W-1:0]            nibbles_left, blk_nibbles;
  logic [BLOCK_CNT_WIDTH-1:0] blk_left;
  logic [TIMEOUT_WIDTH-1:0]   tmo_cnt;
  logic [4:0]                 crc_cnt;
  logic [NIB_IDX_W-1:0]       nib_idx, word_pad;
  logic [FIFO_WIDTH-5:0]      word_sr;
  logic [FIFO_WIDTH-1:0]      word_shift;
  logic                       last_nib, word_done;
  logic                       start_acc, tmo_hit, end_bad, crc_bad, blk_ok, blk_done;

  // Stale nibbles of the previous word sit above the fresh ones and fall off the final left shift.
  assign word_shift = {word_sr, DAT_din};
  assign word_pad   = NIB_IDX_W'(NIBS - 1) - nib_idx;
  assign last_nib   = (nibbles_left == NL_W'(1));
  assign word_done  = (state == ST_RECV_DATA) && (last_nib || nib_idx == NIB_IDX_W'(NIBS - 1));
  assign rd_busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    tmo_hit   = 1'b0;
    end_bad   = 1'b0;
    blk_ok    = 1'b0;
    blk_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (read_flag) begin
          start_acc = 1'b1;
          state_nxt = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (DAT_din == 4'h0) begin
          state_nxt = (nibbles_left == '0) ? ST_RECV_CRC : ST_RECV_DATA;
        end else if (read_timeout != '0 && tmo_cnt == read_timeout - TIMEOUT_WIDTH'(1)) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RECV_DATA: begin
        if (last_nib) state_nxt = ST_RECV_CRC;
      end
      ST_RECV_CRC: begin
        if (crc_cnt == 5'd1) state_nxt = ST_RECV_END;
      end
      ST_RECV_END: begin
        end_bad = (DAT_din != 4'hF);
        if (end_bad || crc_bad) begin
          state_nxt = ST_IDLE;
        end else begin
          blk_ok = 1'b1;
          if (blk_left == BLOCK_CNT_WIDTH'(1)) begin
            blk_done  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_START;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state                <= ST_IDLE;
      nibbles_left         <= '0;
      blk_nibbles          <= '0;
      blk_left             <= '0;
      tmo_cnt              <= '0;
      crc_cnt              <= '0;
      nib_idx              <= '0;
      word_sr              <= '0;
      rx_if.rx_buf_wr_enb  <= 1'b0;
      rx_if.rx_buf_din_out <= '0;
      tf_finished          <= 1'b0;
      end_bit_err          <= 1'b0;
      timeout_err          <= 1'b0;
      overrun_err          <= 1'b0;
    end else begin
      state               <= state_nxt;
      rx_if.rx_buf_wr_enb <= 1'b0;
      tf_finished         <= blk_done;
      end_bit_err         <= end_bad;
      timeout_err         <= tmo_hit;
      crc_cnt             <= (state == ST_RECV_CRC) ? crc_cnt - 5'd1 : 5'd16;
      if (start_acc) begin
        nibbles_left <= {block_sz, 1'b0};
        blk_nibbles  <= {block_sz, 1'b0};
        blk_left     <= (multiple && block_cnt != '0) ? block_cnt : BLOCK_CNT_WIDTH'(1);
        overrun_err  <= 1'b0;
        tmo_cnt      <= '0;
        nib_idx      <= '0;
      end
      if (state == ST_WAIT_START) tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
      // The card cannot be stalled, so a word arriving while the FIFO is full is simply lost.
      if (state == ST_RECV_DATA) begin
        nibbles_left <= nibbles_left - NL_W'(1);
        word_sr      <= word_shift[FIFO_WIDTH-5:0];
        nib_idx      <= word_done ? '0 : nib_idx + NIB_IDX_W'(1);
        if (word_done) begin
          if (rx_if.rx_buf_full) begin
            overrun_err <= 1'b1;
          end else begin
            rx_if.rx_buf_wr_enb  <= 1'b1;
            rx_if.rx_buf_din_out <= word_shift << {word_pad, 2'b00};
          end
        end
      end
      if (blk_ok) begin
        blk_left     <= blk_left - BLOCK_CNT_WIDTH'(1);
        nibbles_left <= blk_nibbles;
        tmo_cnt      <= '0;
      end
    end
  end

`ifdef DAT_RD_CRC_CHECK_EN
  logic [3:0][15:0] crc_calc;
  logic [3:0][15:0] crc_rx;
  logic             crc_clr, crc_en;

  assign crc_clr = (state == ST_IDLE) || (state == ST_WAIT_START);
  assign crc_en  = (state == ST_RECV_DATA);

  for (genvar i = 0; i < 4; i++) begin : g_crc
    sd_crc16 u_crc (
      .sd_clk (sd_clk),
      .rst    (rst),
      .clear  (crc_clr),
      .enable (crc_en),
      .din    (DAT_din[i]),
      .crc    (crc_calc[i])
    );
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      crc_rx  <= '0;
      crc_err <= 1'b0;
    end else begin
      crc_err <= (state == ST_RECV_END) && crc_bad;
      if (state == ST_RECV_CRC) begin
        for (int i = 0; i < 4; i++) crc_rx[i] <= {crc_rx[i][14:0], DAT_din[i]};
      end
    end
  end

  assign crc_bad = (crc_calc != crc_rx);
`else
  assign crc_bad = 1'b0;
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_dat_read_phys.sv
// Directed self-checking bench for dat_read_phys; expectations follow DAT_RD_CRC_CHECK_EN if defined.
module tb_dat_read_phys;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic [3:0]  DAT_din;
  logic [11:0] block_sz;
  logic [15:0] block_cnt;
  logic        multiple;
  logic        read_flag;
  logic [15:0] read_timeout;
  logic        rd_busy, tf_finished, crc_err, end_bit_err, timeout_err, overrun_err;

  dat_read_phys_if #(.FIFO_WIDTH(32)) rx_if ();

  dat_read_phys dut (
    .sd_clk       (sd_clk),
    .rst          (rst),
    .DAT_din      (DAT_din),
    .block_sz     (block_sz),
    .block_cnt    (block_cnt),
    .multiple     (multiple),
    .read_flag    (read_flag),
    .read_timeout (read_timeout),
    .rx_if        (rx_if),
    .rd_busy      (rd_busy),
    .tf_finished  (tf_finished),
    .crc_err      (crc_err),
    .end_bit_err  (end_bit_err),
    .timeout_err  (timeout_err),
    .overrun_err  (overrun_err)
  );

  always #5 sd_clk = ~sd_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] push_q[$];
  int          tf_cnt, crcerr_cnt, enderr_cnt, tmoerr_cnt, busy_gaps;
  logic        in_xfer = 1'b0;

  // Event monitor on the falling edge, well clear of the register updates.
  always @(negedge sd_clk) begin
    if (rx_if.rx_buf_wr_enb) push_q.push_back(rx_if.rx_buf_din_out);
    if (tf_finished) tf_cnt++;
    if (crc_err) crcerr_cnt++;
    if (end_bit_err) enderr_cnt++;
    if (timeout_err) tmoerr_cnt++;
    if (in_xfer && !rd_busy) busy_gaps++;
  end

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pushAt(input int idx);
    if (idx < push_q.size()) return push_q[idx];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic clearMon();
    push_q.delete();
    tf_cnt     = 0;
    crcerr_cnt = 0;
    enderr_cnt = 0;
    tmoerr_cnt = 0;
    busy_gaps  = 0;
  endtask

  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    c  = {c[14:0], 1'b0};
    if (fb) c = c ^ 16'h1021;
    return c;
  endfunction

  task automatic startRead(input int bsz, input int bcnt, input logic mult, input int tmo);
    block_sz     = 12'(bsz);
    block_cnt    = 16'(bcnt);
    multiple     = mult;
    read_timeout = 16'(tmo);
    read_flag    = 1'b1;
    tick();
    read_flag    = 1'b0;
  endtask

  // One card block: idle F nibbles, start nibble, payload MSB-first, per-line CRC16, end nibble.
  task automatic applyStimulus(input logic [63:0] data, input int nnib, input int flip_line,
                               input logic [3:0] end_nib, input int full_word, input int idle);
    logic [15:0] crc[4];
    logic [3:0]  nib;
    for (int i = 0; i < 4; i++) crc[i] = 16'h0000;
    for (int j = 0; j < nnib; j++) begin
      nib = data[63-4*j -: 4];
      for (int i = 0; i < 4; i++) crc[i] = crcStep(crc[i], nib[i]);
    end
    DAT_din = 4'hF;
    repeat (idle) tick();
    DAT_din = 4'h0;
    tick();
    for (int j = 0; j < nnib; j++) begin
      rx_if.rx_buf_full = ((j / 8) == full_word);
      DAT_din = data[63-4*j -: 4];
      tick();
    end
    rx_if.rx_buf_full = 1'b0;
    for (int k = 15; k >= 0; k--) begin
      for (int i = 0; i < 4; i++) DAT_din[i] = crc[i][k] ^ (i == flip_line && k == 0);
      tick();
    end
    DAT_din = end_nib;
    tick();
    DAT_din = 4'hF;
  endtask

  initial begin
    logic exp_crc_err, exp_tf;
    rst               = 1'b1;
    DAT_din           = 4'hF;
    block_sz          = '0;
    block_cnt         = '0;
    multiple          = 1'b0;
    read_flag         = 1'b0;
    read_timeout      = '0;
    rx_if.rx_buf_full = 1'b0;
    clearMon();
    repeat (3) tick();
    checkOutput("rst_busy", rd_busy, 0);
    checkOutput("rst_wr_enb", rx_if.rx_buf_wr_enb, 0);
    checkOutput("rst_din", rx_if.rx_buf_din_out, 0);
    checkOutput("rst_flags", {tf_finished, crc_err, end_bit_err, timeout_err, overrun_err}, 0);
    rst = 1'b0;
    tick();

    $display("[TB] single block, two words");
    clearMon();
    startRead(8, 0, 1'b0, 0);
    checkOutput("t1_busy_start", rd_busy, 1);
    applyStimulus(64'h0123_4567_89AB_CDEF, 16, -1, 4'hF, -1, 3);
    checkOutput("t1_tf_pulse", tf_finished, 1);
    tick();
    checkOutput("t1_push_n", push_q.size(), 2);
    checkOutput("t1_push0", pushAt(0), 32'h0123_4567);
    checkOutput("t1_push1", pushAt(1), 32'h89AB_CDEF);
    checkOutput("t1_tf_cnt", tf_cnt, 1);
    checkOutput("t1_errs", crcerr_cnt + enderr_cnt + tmoerr_cnt, 0);
    checkOutput("t1_idle", rd_busy, 0);

    $display("[TB] multi block, three blocks");
    clearMon();
    startRead(4, 3, 1'b1, 0);
    in_xfer = 1'b1;
    applyStimulus(64'hDEAD_BEEF_0000_0000, 8, -1, 4'hF, -1, 2);
    checkOutput("t2_tf_blk1", tf_finished, 0);
    applyStimulus(64'h1234_5678_0000_0000, 8, -1, 4'hF, -1, 4);
    applyStimulus(64'hCAFE_F00D_0000_0000, 8, -1, 4'hF, -1, 1);
    checkOutput("t2_tf_last", tf_finished, 1);
    in_xfer = 1'b0;
    tick();
    checkOutput("t2_push_n", push_q.size(), 3);
    checkOutput("t2_push0", pushAt(0), 32'hDEAD_BEEF);
    checkOutput("t2_push1", pushAt(1), 32'h1234_5678);
    checkOutput("t2_push2", pushAt(2), 32'hCAFE_F00D);
    checkOutput("t2_tf_cnt", tf_cnt, 1);
    checkOutput("t2_busy_gaps", busy_gaps, 0);

    $display("[TB] start-bit timeout");
    clearMon();
    DAT_din = 4'hF;
    startRead(8, 0, 1'b0, 10);
    repeat (9) tick();
    checkOutput("t3_tmo_early", timeout_err, 0);
    checkOutput("t3_busy_wait", rd_busy, 1);
    tick();
    checkOutput("t3_tmo_pulse", timeout_err, 1);
    checkOutput("t3_idle", rd_busy, 0);
    tick();
    checkOutput("t3_tmo_once", tmoerr_cnt, 1);
    checkOutput("t3_no_push", push_q.size(), 0);

    $display("[TB] corrupted CRC on DAT[2]");
`ifdef DAT_RD_CRC_CHECK_EN
    exp_crc_err = 1'b1;
    exp_tf      = 1'b0;
`else
    exp_crc_err = 1'b0;
    exp_tf      = 1'b1;
`endif
    clearMon();
    startRead(4, 0, 1'b0, 0);
    applyStimulus(64'h5A5A_C3C3_0000_0000, 8, 2, 4'hF, -1, 2);
    checkOutput("t4_crc_err", crc_err, exp_crc_err);
    checkOutput("t4_tf", tf_finished, exp_tf);
    tick();
    checkOutput("t4_push", pushAt(0), 32'h5A5A_C3C3);
    checkOutput("t4_end_ok", enderr_cnt, 0);

    $display("[TB] bad end nibble");
    clearMon();
    startRead(4, 2, 1'b1, 0);
    applyStimulus(64'h0F0F_1E1E_0000_0000, 8, -1, 4'hE, -1, 2);
    checkOutput("t5_end_err", end_bit_err, 1);
    checkOutput("t5_idle", rd_busy, 0);
    tick();
    checkOutput("t5_end_once", enderr_cnt, 1);
    checkOutput("t5_no_tf", tf_cnt, 0);

    $display("[TB] FIFO full during second word");
    clearMon();
    startRead(8, 0, 1'b0, 0);
    applyStimulus(64'h1111_2222_3333_4444, 16, -1, 4'hF, 1, 2);
    checkOutput("t5_ovr_tf", tf_finished, 1);
    repeat (3) tick();
    checkOutput("t5_ovr_push_n", push_q.size(), 1);
    checkOutput("t5_ovr_push0", pushAt(0), 32'h1111_2222);
    checkOutput("t5_ovr_sticky", overrun_err, 1);

    $display("[TB] partial word and empty block");
    clearMon();
    startRead(2, 0, 1'b0, 0);
    checkOutput("t7_ovr_clear", overrun_err, 0);
    applyStimulus(64'h1234_0000_0000_0000, 4, -1, 4'hF, -1, 1);
    startRead(0, 0, 1'b0, 0);
    applyStimulus(64'h0, 0, -1, 4'hF, -1, 2);
    checkOutput("t7_empty_tf", tf_finished, 1);
    tick();
    checkOutput("t7_push_n", push_q.size(), 1);
    checkOutput("t7_pad", pushAt(0), 32'h1234_0000);
    checkOutput("t7_tf_cnt", tf_cnt, 2);

    $display("[TB] reset during payload");
    clearMon();
    startRead(8, 0, 1'b0, 0);
    DAT_din = 4'h0;
    tick();
    rx_if.rx_buf_full = 1'b1;
    for (int j = 0; j < 8; j++) begin
      DAT_din = 4'(j + 1);
      tick();
    end
    rx_if.rx_buf_full = 1'b0;
    checkOutput("t6_ovr_pre", overrun_err, 1);
    for (int j = 0; j < 3; j++) begin
      DAT_din = 4'(j + 9);
      tick();
    end
    DAT_din = 4'hC;
    rst     = 1'b1;
    tick();
    checkOutput("t6_busy", rd_busy, 0);
    checkOutput("t6_outs", {rx_if.rx_buf_wr_enb, tf_finished, crc_err, end_bit_err,
                            timeout_err, overrun_err}, 0);
    rst     = 1'b0;
    DAT_din = 4'hF;
    tick();
    checkOutput("t6_no_push", push_q.size(), 0);
    startRead(4, 0, 1'b0, 0);
    applyStimulus(64'hA5A5_5A5A_0000_0000, 8, -1, 4'hF, -1, 2);
    checkOutput("t6_tf", tf_finished, 1);
    tick();
    checkOutput("t6_push", pushAt(0), 32'hA5A5_5A5A);
    checkOutput("t6_push_n", push_q.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
